branch_predictor: RTL and testbench

- Fetch-side counterpart to the execute-stage branch resolver.
- Predicts taken/target for the fetch PC using a direct-mapped BTB plus a 2-bit saturating-counter BHT.
- Takes back the resolved outcome (taken flag, type, target) from execute.
- Updates its tables, detects mispredictions, and issues a registered one-cycle flush/redirect to the PC logic.

---
 rtl/branch_predictor_pkg.sv | 29 ++
 rtl/bp_btb.sv | 37 +++
 rtl/branch_predictor.sv | 118 +++++++++++
 tb/tb_branch_predictor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor:
// BHT counter encodings, the BTB entry layout and the 2-bit counter update.
package branch_predictor_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Tag is held at full XLEN width (right-justified); unused upper bits stay zero.
    typedef struct packed {
        logic            valid;
        logic            jmp;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
    } btb_entry_t;

    function automatic logic [1:0] sat2_update(input logic [1:0] counter, input logic taken);
        if (taken) begin
            return (counter == ST) ? counter : counter + 2'd1;
        end
        return (counter == SNT) ? counter : counter - 2'd1;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read port plus a
// synchronous write port and a synchronous valid-bit invalidate port.
module bp_btb
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
)
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [IDX_W-1:0]                  rd_idx_i,
    output branch_predictor_pkg::btb_entry_t  rd_entry_o,
    input  logic                              wr_en_i,
    input  logic [IDX_W-1:0]                  wr_idx_i,
    input  branch_predictor_pkg::btb_entry_t  wr_entry_i,
    input  logic                              inv_en_i,
    input  logic [IDX_W-1:0]                  inv_idx_i
);
    import branch_predictor_pkg::*;

    btb_entry_t mem_q [ENTRIES];

    assign rd_entry_o = mem_q[rd_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end else if (inv_en_i) begin
            mem_q[inv_idx_i].valid <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor: BTB + 2-bit BHT lookup, update from the execute
// resolve port, registered mispredict flush/redirect and saturating stats.
module branch_predictor
#(
    parameter int unsigned XLEN    = branch_predictor_pkg::XLEN,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);
    import branch_predictor_pkg::*;

    logic [IDX_W-1:0] if_idx, u_idx;
    logic [XLEN-1:0]  if_tag, u_tag;
    btb_entry_t       rd_entry, wr_entry;
    logic             hit, is_jmp, is_br, wr_en, inv_en, bht_we, mis;
    logic [1:0]       bht_q [ENTRIES];
    logic [1:0]       bht_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  redirect_q, redirect_d;
    logic [31:0]      branches_q, branches_d, mispred_q, mispred_d;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc >> (IDX_W + 2);
    assign u_idx  = ex_pc[IDX_W+1:2];
    assign u_tag  = ex_pc >> (IDX_W + 2);

    bp_btb #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (if_idx),
        .rd_entry_o (rd_entry),
        .wr_en_i    (wr_en),
        .wr_idx_i   (u_idx),
        .wr_entry_i (wr_entry),
        .inv_en_i   (inv_en),
        .inv_idx_i  (u_idx)
    );

    assign hit         = rd_entry.valid && (rd_entry.tag == if_tag);
    assign pred_taken  = hit && (rd_entry.jmp || bht_q[if_idx][1]);
    assign pred_target = hit ? rd_entry.target : '0;

    // A jump wins when both type flags are set.
    assign is_jmp = ex_is_jump;
    assign is_br  = ex_is_branch && !ex_is_jump;

    assign wr_en    = ex_valid && (is_jmp || (is_br && ex_taken));
    assign wr_entry = '{valid: 1'b1, jmp: is_jmp, tag: u_tag, target: ex_target};
    assign inv_en   = ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken;
    assign bht_we   = ex_valid && is_br;
    assign bht_d    = sat2_update(bht_q[u_idx], ex_taken);

    assign mis = ex_valid && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));

    always_comb begin
        flush_d    = mis;
        redirect_d = redirect_q;
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (mis) begin
            redirect_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
        end
        if (ex_valid && (ex_is_branch || ex_is_jump) && (branches_q != '1)) begin
            branches_d = branches_q + 32'd1;
        end
        if (mis && (mispred_q != '1)) begin
            mispred_d = mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= WNT;
            end
            flush_q    <= 1'b0;
            redirect_q <= '0;
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (bht_we) begin
                bht_q[u_idx] <= bht_d;
            end
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expected values.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .XLEN    (32),
        .ENTRIES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_is_branch   = br;
        ex_is_jump     = jmp;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    // Drive one resolve at the negedge; returns #1 after the capturing posedge.
    task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        @(negedge clk);
        set_ex(pc, br, jmp, tk, tgt, ptk, ptgt);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        if (exp_tk) check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        if_pc = '0;
        set_ex('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_stat_br", stat_branches, 32'd0);
        check("rst_stat_mis", stat_mispred, 32'd0);
        check("rst_pred_target", pred_target, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned a = 0; a <= 32'h3C; a += 4) begin
            lookup("sweep", a, 1'b0, 32'd0);
        end
        check("sweep_flush", {31'd0, flush}, 32'd0);

        // Taken branch predicted not-taken: mispredict, install entry, WNT->WT.
        resolve(32'h100, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
        check("br1_flush", {31'd0, flush}, 32'd1);
        check("br1_redirect", redirect_pc, 32'h180);
        check("br1_stat_br", stat_branches, 32'd1);
        check("br1_stat_mis", stat_mispred, 32'd1);
        lookup("br1_lookup", 32'h100, 1'b1, 32'h180);
        @(posedge clk);
        #1;
        check("br1_flush_pulse", {31'd0, flush}, 32'd0);
        check("br1_redirect_hold", redirect_pc, 32'h180);

        // Not taken with pred=1: mispredict to pc+4, WT->WNT.
        resolve(32'h100, 1'b1, 1'b0, 1'b0, 32'h180, 1'b1, 32'h180);
        check("br2_flush", {31'd0, flush}, 32'd1);
        check("br2_redirect", redirect_pc, 32'h104);
        lookup("br2_lookup", 32'h100, 1'b0, 32'h0);

        // Not taken with pred=0: no flush, WNT->SNT, redirect holds.
        resolve(32'h100, 1'b1, 1'b0, 1'b0, 32'h180, 1'b0, 32'h0);
        check("br3_flush", {31'd0, flush}, 32'd0);
        check("br3_redirect_hold", redirect_pc, 32'h104);
        check("br3_stat_br", stat_branches, 32'd3);
        check("br3_stat_mis", stat_mispred, 32'd2);

        // Jump with wrong predicted target (same index 0 as 0x100, different tag).
        resolve(32'h200, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h44);
        check("jmp_flush", {31'd0, flush}, 32'd1);
        check("jmp_redirect", redirect_pc, 32'h40);
        lookup("jmp_lookup", 32'h200, 1'b1, 32'h40);
        lookup("jmp_evict", 32'h100, 1'b0, 32'h0);
        check("jmp_stat_br", stat_branches, 32'd4);
        check("jmp_stat_mis", stat_mispred, 32'd3);

        // Two correctly predicted taken resolves: no flush, SNT->WNT->WT.
        resolve(32'h100, 1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 32'h180);
        check("ok1_flush", {31'd0, flush}, 32'd0);
        lookup("ok1_lookup", 32'h100, 1'b0, 32'h0);
        resolve(32'h100, 1'b1, 1'b0, 1'b1, 32'h180, 1'b1, 32'h180);
        check("ok2_flush", {31'd0, flush}, 32'd0);
        lookup("ok2_lookup", 32'h100, 1'b1, 32'h180);

        // Stale alias: non-branch predicted taken; lookup sees pre-update entry in the same cycle.
        @(negedge clk);
        if_pc = 32'h100;
        set_ex(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h180);
        #1;
        check("alias_pre_update", {31'd0, pred_taken}, 32'd1);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        check("alias_flush", {31'd0, flush}, 32'd1);
        check("alias_redirect", redirect_pc, 32'h104);
        lookup("alias_lookup", 32'h100, 1'b0, 32'h0);
        check("alias_target", pred_target, 32'h0);
        check("alias_stat_br", stat_branches, 32'd6);
        check("alias_stat_mis", stat_mispred, 32'd4);

        // pc+4 wraps to zero.
        resolve(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
        check("wrap_flush", {31'd0, flush}, 32'd1);
        check("wrap_redirect", redirect_pc, 32'h0);

        // Back-to-back mispredicts: two consecutive flush pulses with their own targets.
        @(negedge clk);
        set_ex(32'h300, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("b2b_flush_a", {31'd0, flush}, 32'd1);
        check("b2b_redirect_a", redirect_pc, 32'h500);
        set_ex(32'h340, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        check("b2b_flush_b", {31'd0, flush}, 32'd1);
        check("b2b_redirect_b", redirect_pc, 32'h600);
        check("b2b_stat_br", stat_branches, 32'd9);
        check("b2b_stat_mis", stat_mispred, 32'd7);

        // Mispredict counter saturation.
        @(negedge clk);
        force dut.mispred_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispred_q;
        resolve(32'h400, 1'b1, 1'b0, 1'b1, 32'h480, 1'b0, 32'h0);
        check("sat_step1", stat_mispred, 32'hFFFF_FFFF);
        resolve(32'h400, 1'b1, 1'b0, 1'b0, 32'h480, 1'b1, 32'h480);
        resolve(32'h400, 1'b1, 1'b0, 1'b1, 32'h480, 1'b0, 32'h0);
        check("sat_hold", stat_mispred, 32'hFFFF_FFFF);
        check("sat_stat_br", stat_branches, 32'd12);

        // Reset right after a mispredict drops the pending flush at once.
        resolve(32'h100, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
        check("prerst_flush", {31'd0, flush}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_flush", {31'd0, flush}, 32'd0);
        check("midrst_redirect", redirect_pc, 32'h0);
        check("midrst_stat_br", stat_branches, 32'd0);
        check("midrst_stat_mis", stat_mispred, 32'd0);
        lookup("midrst_lookup", 32'h400, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        resolve(32'h100, 1'b1, 1'b0, 1'b1, 32'h180, 1'b0, 32'h0);
        check("postrst_flush", {31'd0, flush}, 32'd1);
        check("postrst_redirect", redirect_pc, 32'h180);
        check("postrst_stat_br", stat_branches, 32'd1);
        lookup("postrst_lookup", 32'h100, 1'b1, 32'h180);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
